arc4_key_sweep: RTL and testbench

Parametrised successor to the single-shot ARC4 launch/wait controller. It sweeps a key range [key_lo, key_hi] across NUM_CH parallel arc4 cores, each with its own key. For every batch it pulses the core enables, waits for all active cores to report ready, then evaluates their per-core pass flags. It stops on the first passing key, on range exhaustion, or on abort. The block sits between the board top level (start/abort/status) and an array of arc4 cores plus their plaintext checkers.

---
 rtl/arc4_key_sweep.sv | 217 +++++++++++++++++++++
 tb/tb_arc4_key_sweep.sv | 398 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arc4_key_sweep.sv
`default_nettype none
// ============================================================================
//  Module      : arc4_key_sweep
//  Description : Sweeps a key range across NUM_CH parallel arc4 cores and
//                stops on the first passing key, range exhaustion or abort.
//  Revision    : 1.0 - initial release
// ============================================================================
module arc4_key_sweep #(
    parameter int KEY_W  = 24,
    parameter int NUM_CH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    abort,
    input  logic [KEY_W-1:0]        key_lo,
    input  logic [KEY_W-1:0]        key_hi,
    output logic [NUM_CH-1:0]       core_en,
    output logic [NUM_CH*KEY_W-1:0] core_key,
    input  logic [NUM_CH-1:0]       core_rdy,
    input  logic [NUM_CH-1:0]       core_pass,
    output logic                    busy,
    output logic                    done,
    output logic                    found,
    output logic                    aborted,
    output logic [KEY_W-1:0]        found_key,
    output logic [KEY_W:0]          keys_tried
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LAUNCH = 3'd1,
        S_SETTLE = 3'd2,
        S_WAIT   = 3'd3,
        S_EVAL   = 3'd4,
        S_FINISH = 3'd5
    } state_t;

    state_t                    r_state;
    logic [KEY_W-1:0]          r_base;
    logic [KEY_W-1:0]          r_hi;
    logic                      r_abort;
    logic [NUM_CH-1:0]         r_core_en;
    logic [NUM_CH*KEY_W-1:0]   r_core_key;
    logic                      r_busy;
    logic                      r_done;
    logic                      r_found;
    logic                      r_aborted;
    logic [KEY_W-1:0]          r_found_key;
    logic [KEY_W:0]            r_keys_tried;

    logic [NUM_CH-1:0]         w_active;
    logic [NUM_CH-1:0]         w_hit;
    logic                      w_all_rdy;
    logic                      w_abort;
    logic [KEY_W:0]            w_base_step;
    logic                      w_last_batch;
    logic [KEY_W:0]            w_hit_inc;
    logic [KEY_W-1:0]          w_hit_key;
    logic [KEY_W:0]            w_act_cnt;

    // Channel c is active when base+c still lies inside the range; the extra
    // bit keeps the compare honest when the range ends at all-ones.
    function automatic logic [NUM_CH-1:0] active_mask(input logic [KEY_W-1:0] base,
                                                      input logic [KEY_W-1:0] hi);
        logic [NUM_CH-1:0] m;
        m = '0;
        for (int c = 0; c < NUM_CH; c++)
            m[c] = ({1'b0, base} + (KEY_W+1)'(c)) <= {1'b0, hi};
        return m;
    endfunction

    function automatic logic [NUM_CH*KEY_W-1:0] lane_keys(input logic [KEY_W-1:0]  base,
                                                          input logic [NUM_CH-1:0] act);
        logic [NUM_CH*KEY_W-1:0] k;
        k = '0;
        for (int c = 0; c < NUM_CH; c++)
            if (act[c])
                k[c*KEY_W +: KEY_W] = base + KEY_W'(c);
        return k;
    endfunction

    assign w_active     = active_mask(r_base, r_hi);
    assign w_hit        = core_pass & w_active;
    assign w_all_rdy    = &(core_rdy | ~w_active);
    assign w_abort      = r_abort | abort;
    assign w_base_step  = {1'b0, r_base} + (KEY_W+1)'(NUM_CH);
    assign w_last_batch = w_base_step > {1'b0, r_hi};

    // Descending scan so the lowest passing channel is the one that sticks.
    always_comb begin
        w_hit_inc = '0;
        w_hit_key = '0;
        w_act_cnt = '0;
        for (int c = NUM_CH-1; c >= 0; c--) begin
            if (w_hit[c]) begin
                w_hit_inc = (KEY_W+1)'(c + 1);
                w_hit_key = r_base + KEY_W'(c);
            end
        end
        for (int c = 0; c < NUM_CH; c++)
            w_act_cnt = w_act_cnt + (KEY_W+1)'(w_active[c]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_base       <= '0;
            r_hi         <= '0;
            r_abort      <= 1'b0;
            r_core_en    <= '0;
            r_core_key   <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_found      <= 1'b0;
            r_aborted    <= 1'b0;
            r_found_key  <= '0;
            r_keys_tried <= '0;
        end else begin
            r_core_en <= '0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_found      <= 1'b0;
                        r_aborted    <= 1'b0;
                        r_done       <= 1'b0;
                        r_keys_tried <= '0;
                        r_found_key  <= '0;
                        r_abort      <= 1'b0;
                        if (key_lo <= key_hi) begin
                            r_base     <= key_lo;
                            r_hi       <= key_hi;
                            r_busy     <= 1'b1;
                            r_core_key <= lane_keys(key_lo, active_mask(key_lo, key_hi));
                            r_state    <= S_LAUNCH;
                        end else begin
                            r_done  <= 1'b1;
                            r_state <= S_FINISH;
                        end
                    end
                end
                S_LAUNCH: begin
                    if (w_abort) begin
                        r_aborted  <= 1'b1;
                        r_busy     <= 1'b0;
                        r_done     <= 1'b1;
                        r_abort    <= 1'b0;
                        r_core_key <= '0;
                        r_state    <= S_FINISH;
                    end else if (w_all_rdy) begin
                        r_core_en <= w_active;
                        r_state   <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (abort)
                        r_abort <= 1'b1;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (abort)
                        r_abort <= 1'b1;
                    if (w_all_rdy)
                        r_state <= S_EVAL;
                end
                S_EVAL: begin
                    if (w_abort) begin
                        r_aborted  <= 1'b1;
                        r_busy     <= 1'b0;
                        r_done     <= 1'b1;
                        r_abort    <= 1'b0;
                        r_core_key <= '0;
                        r_state    <= S_FINISH;
                    end else if (|w_hit) begin
                        r_found      <= 1'b1;
                        r_found_key  <= w_hit_key;
                        r_keys_tried <= r_keys_tried + w_hit_inc;
                        r_busy       <= 1'b0;
                        r_done       <= 1'b1;
                        r_core_key   <= '0;
                        r_state      <= S_FINISH;
                    end else begin
                        r_keys_tried <= r_keys_tried + w_act_cnt;
                        if (w_last_batch) begin
                            r_busy     <= 1'b0;
                            r_done     <= 1'b1;
                            r_core_key <= '0;
                            r_state    <= S_FINISH;
                        end else begin
                            r_base     <= w_base_step[KEY_W-1:0];
                            r_core_key <= lane_keys(w_base_step[KEY_W-1:0],
                                                    active_mask(w_base_step[KEY_W-1:0], r_hi));
                            r_state    <= S_LAUNCH;
                        end
                    end
                end
                S_FINISH: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign core_en    = r_core_en;
    assign core_key   = r_core_key;
    assign busy       = r_busy;
    assign done       = r_done;
    assign found      = r_found;
    assign aborted    = r_aborted;
    assign found_key  = r_found_key;
    assign keys_tried = r_keys_tried;

endmodule
`default_nettype wire

// File: tb/tb_arc4_key_sweep.sv
`default_nettype none
// ============================================================================
//  Module      : tb_arc4_key_sweep
//  Description : Self-checking bench for arc4_key_sweep with modelled cores.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_arc4_key_sweep;

    localparam int KEY_W  = 24;
    localparam int NUM_CH = 4;
    localparam int LAT    = 10;

    logic                    clk;
    logic                    rst;
    logic                    start;
    logic                    abort;
    logic [KEY_W-1:0]        key_lo;
    logic [KEY_W-1:0]        key_hi;
    logic [NUM_CH-1:0]       core_en;
    logic [NUM_CH*KEY_W-1:0] core_key;
    logic [NUM_CH-1:0]       core_rdy;
    logic [NUM_CH-1:0]       core_pass;
    logic                    busy;
    logic                    done;
    logic                    found;
    logic                    aborted;
    logic [KEY_W-1:0]        found_key;
    logic [KEY_W:0]          keys_tried;

    int n_checks = 0;
    int n_pass   = 0;

    logic             hold_rdy;
    bit               pass_en_a, pass_en_b;
    logic [KEY_W-1:0] pass_key_a, pass_key_b;
    longint           cur_lo, cur_hi;

    int en_total      = 0;
    int batch_total   = 0;
    int bad_key_total = 0;

    arc4_key_sweep #(.KEY_W(KEY_W), .NUM_CH(NUM_CH)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .key_lo     (key_lo),
        .key_hi     (key_hi),
        .core_en    (core_en),
        .core_key   (core_key),
        .core_rdy   (core_rdy),
        .core_pass  (core_pass),
        .busy       (busy),
        .done       (done),
        .found      (found),
        .aborted    (aborted),
        .found_key  (found_key),
        .keys_tried (keys_tried)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit is_pass(input logic [KEY_W-1:0] k);
        return (pass_en_a && k == pass_key_a) || (pass_en_b && k == pass_key_b);
    endfunction

    // Core models: LAT cycles busy after en, then ready with a pass verdict.
    logic [NUM_CH-1:0] m_rdy, m_pass;
    int                m_cnt [NUM_CH];
    logic [KEY_W-1:0]  m_key [NUM_CH];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_rdy  <= '1;
            m_pass <= '0;
            for (int c = 0; c < NUM_CH; c++) m_cnt[c] <= 0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (core_en[c]) begin
                    m_rdy[c]  <= 1'b0;
                    m_pass[c] <= 1'b0;
                    m_cnt[c]  <= LAT;
                    m_key[c]  <= core_key[c*KEY_W +: KEY_W];
                end else if (m_cnt[c] > 0) begin
                    m_cnt[c] <= m_cnt[c] - 1;
                    if (m_cnt[c] == 1) begin
                        m_rdy[c]  <= 1'b1;
                        m_pass[c] <= is_pass(m_key[c]);
                    end
                end
            end
        end
    end

    assign core_rdy  = m_rdy & ~{NUM_CH{hold_rdy}};
    assign core_pass = m_pass;

    function automatic int bad_keys(input logic [NUM_CH-1:0] en, input logic [NUM_CH*KEY_W-1:0] keys,
                                    input longint lo, input longint hi);
        int               n;
        logic [KEY_W-1:0] k;
        n = 0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (en[c]) begin
                k = keys[c*KEY_W +: KEY_W];
                if (longint'(k) < lo || longint'(k) > hi) n++;
            end
        end
        return n;
    endfunction

    always @(posedge clk) begin
        if (!rst && core_en != '0) begin
            batch_total   <= batch_total + 1;
            en_total      <= en_total + $countones(core_en);
            bad_key_total <= bad_key_total + bad_keys(core_en, core_key, cur_lo, cur_hi);
        end
    end

    // Reference: walk keys in order; first passing key ends the sweep. Keys
    // launched = whole batches up to the one holding the last evaluated key.
    task automatic ref_sweep(input longint lo, input longint hi, output bit e_found,
                             output longint e_key, output longint e_tried, output longint e_pulses);
        longint nb, last_launched;
        e_found = 0; e_key = 0; e_tried = 0; e_pulses = 0;
        if (lo <= hi) begin
            for (longint k = lo; k <= hi; k++) begin
                e_tried++;
                if (is_pass(KEY_W'(k))) begin
                    e_found = 1;
                    e_key   = k;
                    break;
                end
            end
            nb            = (e_tried + NUM_CH - 1) / NUM_CH;
            last_launched = lo + nb * NUM_CH - 1;
            if (last_launched > hi) last_launched = hi;
            e_pulses      = last_launched - lo + 1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input string name, input int limit);
        int n;
        n = 0;
        while (done !== 1'b1 && n < limit) begin
            tick();
            n++;
        end
        n_checks++;
        if (done !== 1'b1) $display("FAIL %s done_timeout: done=%b after %0d cycles, required 1", name, done, n);
        else n_pass++;
    endtask

    task automatic run_sweep(input string name, input longint lo, input longint hi,
                             input bit with_abort, input bit poke);
        bit     e_found;
        longint e_key, e_tried, e_pulses;
        int     e0, bad0, n;
        ref_sweep(lo, hi, e_found, e_key, e_tried, e_pulses);
        e0 = en_total; bad0 = bad_key_total;
        cur_lo = lo; cur_hi = hi;
        key_lo = KEY_W'(lo); key_hi = KEY_W'(hi);
        start = 1'b1; abort = with_abort;
        tick();
        start = 1'b0; abort = 1'b0;
        if (lo <= hi) begin
            n_checks++;
            if (busy !== 1'b1 || done !== 1'b0 || found !== 1'b0)
                $display("FAIL %s start_state: busy=%b done=%b found=%b, required 1/0/0", name, busy, done, found);
            else n_pass++;
        end
        n = 0;
        while (done !== 1'b1 && n < 3000) begin
            start = poke && (n == 5);
            if (start) begin key_lo = '0; key_hi = '1; end
            tick();
            start = 1'b0;
            n++;
        end
        n_checks++;
        if (done !== 1'b1) $display("FAIL %s done: done=%b, required 1", name, done); else n_pass++;
        n_checks++;
        if (busy !== 1'b0) $display("FAIL %s busy: busy=%b, required 0", name, busy); else n_pass++;
        n_checks++;
        if (found !== e_found) $display("FAIL %s found: found=%b, required %0d", name, found, e_found); else n_pass++;
        if (e_found) begin
            n_checks++;
            if (found_key !== KEY_W'(e_key))
                $display("FAIL %s found_key: got %h, required %h", name, found_key, KEY_W'(e_key));
            else n_pass++;
        end
        n_checks++;
        if (keys_tried !== (KEY_W+1)'(e_tried))
            $display("FAIL %s keys_tried: got %0d, required %0d", name, keys_tried, e_tried);
        else n_pass++;
        n_checks++;
        if (aborted !== 1'b0) $display("FAIL %s aborted: got %b, required 0", name, aborted); else n_pass++;
        n_checks++;
        if (longint'(en_total - e0) !== e_pulses)
            $display("FAIL %s en_pulses: got %0d, required %0d", name, en_total - e0, e_pulses);
        else n_pass++;
        n_checks++;
        if (bad_key_total !== bad0)
            $display("FAIL %s key_range: %0d out-of-range keys launched, required 0", name, bad_key_total - bad0);
        else n_pass++;
        tick();
        tick();
    endtask

    task automatic set_pass(input bit ea, input logic [KEY_W-1:0] ka, input bit eb, input logic [KEY_W-1:0] kb);
        pass_en_a = ea; pass_key_a = ka; pass_en_b = eb; pass_key_b = kb;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({core_en, core_key, busy, done, found, aborted, found_key, keys_tried} !== '0)
            $display("FAIL reset_outputs: en=%h busy=%b done=%b found=%b aborted=%b tried=%0d, required all 0",
                     core_en, busy, done, found, aborted, keys_tried);
        else n_pass++;
        #3 rst = 1'b0;
        tick();
    endtask

    task automatic test_directed();
        set_pass(1, 24'h000006, 0, 24'h0);
        run_sweep("found_key6", 64'h0, 64'hB, 0, 0);
        set_pass(0, 24'h0, 0, 24'h0);
        run_sweep("partial_batch", 64'h2, 64'h4, 0, 0);
        run_sweep("top_of_range", 64'hFFFFFE, 64'hFFFFFF, 0, 0);
        set_pass(1, 24'h000013, 1, 24'h000011);
        run_sweep("multi_pass", 64'h10, 64'h1F, 0, 0);
    endtask

    task automatic test_empty_range();
        int e0;
        e0 = en_total;
        key_lo = 24'h000009; key_hi = 24'h000003;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done("empty_range", 2);
        n_checks++;
        if (found !== 1'b0 || keys_tried !== '0 || busy !== 1'b0 || en_total !== e0)
            $display("FAIL empty_range result: found=%b tried=%0d busy=%b en=%0d, required 0/0/0/0",
                     found, keys_tried, busy, en_total - e0);
        else n_pass++;
        tick();
        tick();
    endtask

    task automatic test_abort_wait();
        int bs, e0, n;
        set_pass(0, 24'h0, 0, 24'h0);
        bs = batch_total; e0 = en_total;
        cur_lo = 0; cur_hi = 64'h3F;
        key_lo = 24'h0; key_hi = 24'h3F;
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (batch_total - bs < 2 && n < 200) begin tick(); n++; end
        repeat (3) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        wait_done("abort_wait", 200);
        n_checks++;
        if (aborted !== 1'b1 || found !== 1'b0)
            $display("FAIL abort_wait flags: aborted=%b found=%b, required 1/0", aborted, found);
        else n_pass++;
        n_checks++;
        if (keys_tried !== (KEY_W+1)'(NUM_CH))
            $display("FAIL abort_wait keys_tried: got %0d, required %0d", keys_tried, NUM_CH);
        else n_pass++;
        repeat (LAT + 4) tick();
        n_checks++;
        if (batch_total - bs !== 2 || en_total - e0 !== 2 * NUM_CH)
            $display("FAIL abort_wait batches: got %0d batches %0d en, required 2 batches %0d en",
                     batch_total - bs, en_total - e0, 2 * NUM_CH);
        else n_pass++;
    endtask

    task automatic test_abort_launch();
        int e0;
        e0 = en_total;
        hold_rdy = 1'b1;
        key_lo = 24'h0; key_hi = 24'h7;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        n_checks++;
        if (busy !== 1'b1 || en_total !== e0)
            $display("FAIL abort_launch stall: busy=%b en=%0d, required 1/0", busy, en_total - e0);
        else n_pass++;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        wait_done("abort_launch", 2);
        n_checks++;
        if (aborted !== 1'b1 || keys_tried !== '0 || en_total !== e0 || busy !== 1'b0)
            $display("FAIL abort_launch result: aborted=%b tried=%0d en=%0d busy=%b, required 1/0/0/0",
                     aborted, keys_tried, en_total - e0, busy);
        else n_pass++;
        hold_rdy = 1'b0;
        tick();
    endtask

    task automatic test_abort_idle();
        set_pass(1, 24'h000022, 0, 24'h0);
        run_sweep("pre_idle_abort", 64'h20, 64'h27, 0, 0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        repeat (3) tick();
        n_checks++;
        if (aborted !== 1'b0 || found !== 1'b1 || done !== 1'b1 || busy !== 1'b0)
            $display("FAIL abort_idle: aborted=%b found=%b done=%b busy=%b, required 0/1/1/0",
                     aborted, found, done, busy);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        set_pass(1, 24'h000035, 0, 24'h0);
        run_sweep("start_with_abort", 64'h30, 64'h3A, 1, 0);
        set_pass(1, 24'h00004B, 0, 24'h0);
        run_sweep("start_while_busy", 64'h41, 64'h50, 0, 1);
    endtask

    task automatic test_reset_mid();
        key_lo = 24'h0; key_hi = 24'h40;
        cur_lo = 0; cur_hi = 64'h40;
        set_pass(0, 24'h0, 0, 24'h0);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (15) tick();
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({core_en, core_key, busy, done, found, aborted, found_key, keys_tried} !== '0)
            $display("FAIL reset_mid outputs: en=%h busy=%b done=%b tried=%0d, required all 0",
                     core_en, busy, done, keys_tried);
        else n_pass++;
        #2 rst = 1'b0;
        repeat (2) tick();
        set_pass(1, 24'h000008, 0, 24'h0);
        run_sweep("after_reset", 64'h5, 64'h9, 0, 0);
    endtask

    task automatic test_random();
        longint lo, hi, len;
        for (int it = 0; it < 10; it++) begin
            if ($urandom_range(0, 3) == 0) lo = 64'hFFFFFF - longint'($urandom_range(0, 10));
            else lo = longint'($urandom & 32'h00FF_FFFF);
            len = longint'($urandom_range(0, 24));
            hi  = (lo + len > 64'hFFFFFF) ? 64'hFFFFFF : lo + len;
            if ($urandom_range(0, 5) == 0 && lo > 0) hi = lo - 1;
            set_pass($urandom_range(0, 1) == 1, KEY_W'(lo + longint'($urandom_range(0, 26))),
                     $urandom_range(0, 1) == 1, KEY_W'(lo + longint'($urandom_range(0, 26))));
            run_sweep("random", lo, hi, 0, 0);
        end
    endtask

    initial begin
        start = 1'b0; abort = 1'b0; key_lo = '0; key_hi = '0; hold_rdy = 1'b0;
        cur_lo = 0; cur_hi = 0;
        set_pass(0, 24'h0, 0, 24'h0);
        test_reset();
        test_directed();
        test_empty_range();
        test_abort_wait();
        test_abort_launch();
        test_abort_idle();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
